// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall hold and flush bubble
// Optional statistics counters: define ID_EX_STATS_EN.
module id_ex_pipe_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [9:0]    id_ctrl,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic          ex_reg_dst,
  output logic          ex_alu_src,
  output logic [1:0]    ex_alu_op,
  output logic          ex_jump
`ifdef ID_EX_STATS_EN
  ,
  output logic [15:0]   bubble_cnt,
  output logic [15:0]   hold_cnt
`endif
);

  // A non-valid slot must never write registers or memory, so its control is zeroed.
  logic [9:0] ctrl_load;
  assign ctrl_load = id_valid ? id_ctrl : 10'd0;

  // Pipeline state: reset clears, flush inserts a bubble, stall holds, otherwise load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_jump       <= 1'b0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_jump       <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_pc4        <= id_pc4;
      ex_rd1        <= id_rd1;
      ex_rd2        <= id_rd2;
      ex_imm        <= id_imm;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_reg_write  <= ctrl_load[9];
      ex_mem_to_reg <= ctrl_load[8];
      ex_mem_read   <= ctrl_load[7];
      ex_mem_write  <= ctrl_load[6];
      ex_branch     <= ctrl_load[5];
      ex_reg_dst    <= ctrl_load[4];
      ex_alu_src    <= ctrl_load[3];
      ex_alu_op     <= ctrl_load[2:1];
      ex_jump       <= ctrl_load[0];
    end
  end

`ifdef ID_EX_STATS_EN
  // Saturating counts of bubble edges and hold edges; flush wins over stall as above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 16'd0;
      hold_cnt   <= 16'd0;
    end else if (flush) begin
      if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end else if (stall) begin
      if (hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Pipeline register between ID and EX in the 5-stage MIPS datapath. Captures decoded control bits, register-file read data, sign-extended immediate and register specifiers at each rising clock edge. Presents them to EX, where `ex_alu_src` drives the select of the 32-bit ALU-operand 2:1 mux choosing between `ex_rd2` and `ex_imm`. Supports hold (stall) and bubble insertion (flush) under hazard-unit control.

## Interface
Parameters:
- `DW`, 32: datapath width (PC, read data, immediate).
- `RW`, 5: register specifier width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold all stored fields.
- `flush`  in  1  load a bubble (NOP) instead of ID values.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc4`  in  DW  PC+4 of ID instruction.
- `id_rd1`, `id_rd2`  in  DW each  register-file read data.
- `id_imm`  in  DW  sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  RW each  register specifiers.
- `id_ctrl`  in  10  {reg_write, mem_to_reg, mem_read, mem_write, branch, reg_dst, alu_src, alu_op[1:0], jump}, MSB first.
- `ex_valid`  out  1  EX slot holds a real instruction.
- `ex_pc4`, `ex_rd1`, `ex_rd2`, `ex_imm`  out  DW each  registered copies.
- `ex_rs`, `ex_rt`, `ex_rd`  out  RW each  registered copies.
- `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_reg_dst`, `ex_alu_src`, `ex_jump`  out  1 each  control bits.
- `ex_alu_op`  out  2  ALU control class.
- `bubble_cnt`, `hold_cnt`  out  16 each  statistics (present only with `ID_EX_STATS_EN`).

## Operation
Action at each rising `clk` edge, highest priority first:
- `rst_n` low (asynchronous, no edge needed): every output 0, including `ex_valid`, all data, all control and the counters.
- `flush`=1: bubble. `ex_valid`=0, all control outputs 0, all data and specifier outputs 0. Flush overrides `stall`.
- `stall`=1, `flush`=0: every output retains its value.
- Otherwise: load. Each `ex_*` takes its `id_*` value; `ex_valid` = `id_valid`.
- `id_valid`=0 on load: control outputs are forced to 0 regardless of `id_ctrl`, so a non-valid slot never writes registers or memory. Data fields load normally.
- No arithmetic; the block is a pure registered transfer. Widths pass through unchanged.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs. All outputs come straight from flops; there is no combinational input-to-output path.
- Reset release is synchronous to use: the first edge with `rst_n` high performs a normal priority evaluation.
- Load-use hazard: the hazard unit asserts `flush` for one cycle. EX then sees exactly one bubble while IF/ID holds upstream.
- `stall` held for N cycles: outputs are frozen for N edges, and the load happens on the first edge after `stall` falls.
- Simultaneous `stall` and `flush`: the result is a bubble.

## Configuration
- `ID_EX_STATS_EN` defined adds two 16-bit saturating counters, reset to 0:
  - `bubble_cnt` increments on every edge where the flush branch is taken.
  - `hold_cnt` increments on every edge where the stall branch is taken.
  - Both stop at 16'hFFFF.
- `ID_EX_STATS_EN` undefined: the counters and both ports are absent. All other behaviour is identical.

## Test plan
- Reset: drive inputs non-zero and assert `rst_n`=0 mid-cycle -> all outputs 0 immediately, before the next edge.
- Load: `id_rd2`=32'h0000_00AA, `id_imm`=32'hFFFF_FFF0, `id_ctrl`=10'b1000001000 (reg_write, alu_src), `id_valid`=1 -> after one edge, `ex_rd2`=32'h0000_00AA, `ex_imm`=32'hFFFF_FFF0, `ex_alu_src`=1, `ex_reg_write`=1, `ex_valid`=1.
- Stall: load as above, then `stall`=1 for 3 cycles while inputs change to `id_rd2`=32'h1234_5678 -> outputs stay 32'h0000_00AA for 3 edges; 32'h1234_5678 appears on the edge after `stall` drops; `hold_cnt`=3 (stats build).
- Flush priority: `stall`=1, `flush`=1, with valid lw control (mem_read=1) -> next edge `ex_valid`=0, all control 0, `ex_imm`=0; `bubble_cnt`=1.
- Invalid slot: `id_valid`=0, `id_ctrl`=10'h3FF, `id_rs`=5'd9 -> all control outputs 0, `ex_rs`=5'd9, `ex_valid`=0.
- Saturation (stats build): hold `flush`=1 for 65 540 cycles -> `bubble_cnt`=16'hFFFF and stays there, `hold_cnt`=0.
